uart_param_loader: RTL and testbench

- Receives pulse-sequence parameters from the LabView host over a UART line and presents them as stable parallel registers to the pulse generator downstream.
- Issues a one-cycle load strobe only after a complete, checksum-valid frame.
- Sits between the FPGA rx pin and the pulse generator's per/p1wid/del/p2wid/p_bl/pu/cp/bl/rxd inputs.
- Contains a UART byte receiver and a frame parser.

---
 rtl/pulses_pkg.sv | 25 ++
 rtl/uart_rx_byte.sv | 97 +++++++++
 rtl/uart_param_loader.sv | 142 ++++++++++++++
 tb/tb_uart_param_loader.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pulses_pkg.sv
// Shared constants for the pulse-sequence parameter path: frame layout, reset defaults
// (also used by the pulse generator) and the state encodings of the loader.
package pulses_pkg;

  localparam logic [7:0] HEADER            = 8'hA5;
  localparam int         FRAME_PAYLOAD_LEN = 9;

  localparam int FLG_PU = 0;
  localparam int FLG_CP = 1;
  localparam int FLG_BL = 2;

  localparam logic [7:0]  DEF_PER   = 8'd1;
  localparam logic [15:0] DEF_P1WID = 16'd30;
  localparam logic [15:0] DEF_DEL   = 16'd200;
  localparam logic [15:0] DEF_P2WID = 16'd30;
  localparam logic [7:0]  DEF_P_BL  = 8'd50;
  localparam logic        DEF_PU    = 1'b1;
  localparam logic        DEF_CP    = 1'b1;
  localparam logic        DEF_BL    = 1'b1;

  typedef enum logic [1:0] {HUNT, PAYLOAD, CHECK} parser_state_t;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchronizer, mid-bit sampling, and a one-cycle
// byte_valid or byte_err strobe at the stop bit.
module uart_rx_byte
  import pulses_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1745
) (
  input  logic       clk_pll,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       byte_valid,
  output logic       byte_err
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

  logic          rx_meta, rx_sync;
  rx_state_t     state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shreg, shreg_n;
  logic          valid_n, err_n;

  assign data = shreg;

  always_ff @(posedge clk_pll) begin
    if (!reset) begin
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
    end else begin
      rx_meta    <= rx;
      rx_sync    <= rx_meta;
      state      <= state_n;
      cnt        <= cnt_n;
      bit_idx    <= bit_idx_n;
      shreg      <= shreg_n;
      byte_valid <= valid_n;
      byte_err   <= err_n;
    end
  end

  // The start bit is re-checked at its midpoint so later samples land mid-bit
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    valid_n   = 1'b0;
    err_n     = 1'b0;
    case (state)
      RX_IDLE: begin
        cnt_n = '0;
        if (!rx_sync) state_n = RX_START;
      end
      RX_START: begin
        if (cnt == HALF_LAST) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          state_n   = rx_sync ? RX_IDLE : RX_DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt == FULL_LAST) begin
          cnt_n   = '0;
          shreg_n = {rx_sync, shreg[7:1]};
          if (bit_idx == 3'd7) state_n = RX_STOP;
          else bit_idx_n = bit_idx + 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt == FULL_LAST) begin
          cnt_n   = '0;
          valid_n = rx_sync;
          err_n   = !rx_sync;
          state_n = RX_IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_param_loader.sv
// Receives checksummed 11-byte parameter frames over UART and presents them as stable
// registers to the pulse generator, with a one-cycle load strobe per accepted frame.
module uart_param_loader #(
  parameter int         CLKS_PER_BIT = 1745,
  parameter int         BYTE_TIMEOUT = 34900,
  parameter logic [7:0] HEADER       = pulses_pkg::HEADER
) (
  input  logic        clk_pll,
  input  logic        reset,
  input  logic        uart_rx,
  output logic [7:0]  per,
  output logic [15:0] p1wid,
  output logic [15:0] del,
  output logic [15:0] p2wid,
  output logic [7:0]  p_bl,
  output logic        pu,
  output logic        cp,
  output logic        bl,
  output logic        load,
  output logic        frame_err
);

  import pulses_pkg::*;

  localparam int            TW       = $clog2(BYTE_TIMEOUT + 1);
  localparam logic [3:0]    LAST_IDX = 4'(FRAME_PAYLOAD_LEN - 1);
  localparam logic [TW-1:0] TMO_VAL  = TW'(BYTE_TIMEOUT);

  logic [7:0]    byte_data;
  logic          byte_valid, byte_err;

  parser_state_t state, state_n;
  logic [3:0]    idx;
  logic [7:0]    chk;
  logic [TW-1:0] idle_cnt;
  logic [7:0]    shadow [0:7];
  logic [2:0]    flg_sh;
  logic          start, take, commit, abort, timeout;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk_pll    (clk_pll),
    .reset      (reset),
    .rx         (uart_rx),
    .data       (byte_data),
    .byte_valid (byte_valid),
    .byte_err   (byte_err)
  );

  always_ff @(posedge clk_pll) begin
    if (!reset) state <= HUNT;
    else        state <= state_n;
  end

  // A header value inside the payload is plain data; only HUNT looks for it
  always_comb begin
    state_n = state;
    start   = 1'b0;
    take    = 1'b0;
    commit  = 1'b0;
    abort   = 1'b0;
    timeout = (idle_cnt == TMO_VAL);
    case (state)
      HUNT: begin
        if (byte_valid && byte_data == HEADER) begin
          start   = 1'b1;
          state_n = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (byte_err || timeout) begin
          abort   = 1'b1;
          state_n = HUNT;
        end else if (byte_valid) begin
          take = 1'b1;
          if (idx == LAST_IDX) state_n = CHECK;
        end
      end
      CHECK: begin
        if (byte_err || timeout) begin
          abort   = 1'b1;
          state_n = HUNT;
        end else if (byte_valid) begin
          state_n = HUNT;
          if (byte_data == chk) commit = 1'b1;
          else                  abort  = 1'b1;
        end
      end
      default: state_n = HUNT;
    endcase
  end

  // Outputs and load register on the same edge, so values are settled while load is high
  always_ff @(posedge clk_pll) begin
    if (!reset) begin
      idx       <= '0;
      chk       <= '0;
      idle_cnt  <= '0;
      flg_sh    <= '0;
      for (int i = 0; i < 8; i++) shadow[i] <= '0;
      per       <= DEF_PER;
      p1wid     <= DEF_P1WID;
      del       <= DEF_DEL;
      p2wid     <= DEF_P2WID;
      p_bl      <= DEF_P_BL;
      pu        <= DEF_PU;
      cp        <= DEF_CP;
      bl        <= DEF_BL;
      load      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      load      <= commit;
      frame_err <= abort;

      if (state == HUNT || byte_valid) idle_cnt <= '0;
      else if (!timeout)               idle_cnt <= idle_cnt + 1'b1;

      if (start) begin
        idx <= '0;
        chk <= '0;
      end else if (take) begin
        if (idx == LAST_IDX)
          flg_sh <= {byte_data[FLG_BL], byte_data[FLG_CP], byte_data[FLG_PU]};
        else
          shadow[idx[2:0]] <= byte_data;
        chk <= chk ^ byte_data;
        idx <= idx + 1'b1;
      end

      if (commit) begin
        per   <= shadow[0];
        p1wid <= {shadow[1], shadow[2]};
        del   <= {shadow[3], shadow[4]};
        p2wid <= {shadow[5], shadow[6]};
        p_bl  <= shadow[7];
        pu    <= flg_sh[0];
        cp    <= flg_sh[1];
        bl    <= flg_sh[2];
      end
    end
  end

endmodule

// File: tb/tb_uart_param_loader.sv
// Directed bench for uart_param_loader: UART frames are driven serially and the expected
// parameter set of each good frame is queued, then checked when the DUT raises load.
module tb_uart_param_loader;

  localparam int CPB = 16;
  localparam int TMO = 320;

  typedef struct {
    logic [7:0]  per;
    logic [15:0] p1wid, del, p2wid;
    logic [7:0]  p_bl;
    logic        pu, cp, bl;
  } params_t;

  logic        clk_pll = 1'b0;
  logic        reset   = 1'b0;
  logic        uart_rx = 1'b1;
  logic [7:0]  per, p_bl;
  logic [15:0] p1wid, del, p2wid;
  logic        pu, cp, bl, load, frame_err;

  int      n_checks = 0;
  int      n_fail   = 0;
  int      load_cnt = 0;
  int      err_cnt  = 0;
  int      exp_load = 0;
  int      exp_err  = 0;
  logic    load_prev = 1'b0;
  params_t exp_q[$];
  params_t p_def, p_good, p_alt, p_last;

  uart_param_loader #(.CLKS_PER_BIT(CPB), .BYTE_TIMEOUT(TMO)) dut (
    .clk_pll   (clk_pll),
    .reset     (reset),
    .uart_rx   (uart_rx),
    .per       (per),
    .p1wid     (p1wid),
    .del       (del),
    .p2wid     (p2wid),
    .p_bl      (p_bl),
    .pu        (pu),
    .cp        (cp),
    .bl        (bl),
    .load      (load),
    .frame_err (frame_err)
  );

  always #5 clk_pll = ~clk_pll;

  function automatic params_t mkParams(logic [7:0] pr, logic [15:0] w1, logic [15:0] d,
                                       logic [15:0] w2, logic [7:0] b, logic u, logic c,
                                       logic k);
    params_t p;
    p.per = pr; p.p1wid = w1; p.del = d; p.p2wid = w2; p.p_bl = b;
    p.pu = u; p.cp = c; p.bl = k;
    return p;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkParams(input string tag, input params_t e);
    checkOutput({tag, ".per"},   32'(per),   32'(e.per));
    checkOutput({tag, ".p1wid"}, 32'(p1wid), 32'(e.p1wid));
    checkOutput({tag, ".del"},   32'(del),   32'(e.del));
    checkOutput({tag, ".p2wid"}, 32'(p2wid), 32'(e.p2wid));
    checkOutput({tag, ".p_bl"},  32'(p_bl),  32'(e.p_bl));
    checkOutput({tag, ".pu"},    32'(pu),    32'(e.pu));
    checkOutput({tag, ".cp"},    32'(cp),    32'(e.cp));
    checkOutput({tag, ".bl"},    32'(bl),    32'(e.bl));
  endtask

  task automatic checkCounts(input string tag);
    checkOutput({tag, ".loads"},  32'(load_cnt), 32'(exp_load));
    checkOutput({tag, ".errors"}, 32'(err_cnt),  32'(exp_err));
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_pll);
  endtask

  // One 8N1 character; stop selects a good (1) or broken (0) stop bit
  task automatic applyStimulus(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      idle(CPB);
    end
    uart_rx = stop;
    idle(CPB);
    uart_rx = 1'b1;
  endtask

  task automatic sendFrame(input params_t p, input logic [7:0] chk_flip, input int bad_stop_at,
                           input int glitch_after, input int n_bytes);
    logic [7:0] fr [11];
    fr[0]  = 8'hA5;
    fr[1]  = p.per;
    fr[2]  = p.p1wid[15:8];
    fr[3]  = p.p1wid[7:0];
    fr[4]  = p.del[15:8];
    fr[5]  = p.del[7:0];
    fr[6]  = p.p2wid[15:8];
    fr[7]  = p.p2wid[7:0];
    fr[8]  = p.p_bl;
    fr[9]  = {5'b00000, p.bl, p.cp, p.pu};
    fr[10] = 8'h00;
    for (int i = 1; i < 10; i++) fr[10] = fr[10] ^ fr[i];
    fr[10] = fr[10] ^ chk_flip;
    for (int i = 0; i < n_bytes; i++) begin
      applyStimulus(fr[i], (i != bad_stop_at));
      if (i == glitch_after) begin
        idle(8);
        uart_rx = 1'b0;
        idle(4);
        uart_rx = 1'b1;
        idle(20);
      end
    end
  endtask

  // Scoreboard side: count strobes and compare outputs against the queued frame on load
  always @(negedge clk_pll) begin
    if (reset) begin
      if (frame_err) err_cnt++;
      if (load) begin
        load_cnt++;
        checkOutput("load_width", 32'(load_prev), 32'd0);
        if (exp_q.size() > 0) checkParams("load", exp_q.pop_front());
      end
    end
    load_prev = load;
  end

  initial begin
    p_def  = mkParams(8'd1, 16'd30, 16'd200, 16'd30, 8'd50, 1'b1, 1'b1, 1'b1);
    p_good = mkParams(8'h04, 16'h003C, 16'h0190, 16'h003C, 8'h19, 1'b0, 1'b1, 1'b1);
    p_alt  = mkParams(8'h07, 16'h1234, 16'hA5A5, 16'h0102, 8'hA5, 1'b1, 1'b0, 1'b0);
    p_last = mkParams(8'h02, 16'h0005, 16'h8000, 16'h00FE, 8'h00, 1'b0, 1'b0, 1'b1);

    $display("[TB] reset and idle line");
    uart_rx = 1'b1;
    reset   = 1'b0;
    idle(5);
    reset = 1'b1;
    idle(1);
    checkParams("reset", p_def);
    idle(1000);
    checkCounts("idle");

    $display("[TB] good frame");
    exp_q.push_back(p_good);
    exp_load++;
    sendFrame(p_good, 8'h00, -1, -1, 11);
    idle(40);
    checkCounts("good");
    checkParams("good_hold", p_good);

    $display("[TB] bad checksum");
    exp_err++;
    sendFrame(p_good, 8'h01, -1, -1, 11);
    idle(40);
    checkCounts("bad_chk");
    exp_err++;
    sendFrame(p_alt, 8'h01, -1, -1, 11);
    idle(40);
    checkCounts("bad_chk_alt");
    checkParams("bad_chk_hold", p_good);

    $display("[TB] line glitches");
    uart_rx = 1'b0;
    idle(4);
    uart_rx = 1'b1;
    idle(200);
    checkCounts("glitch_idle");
    exp_q.push_back(p_alt);
    exp_load++;
    sendFrame(p_alt, 8'h00, -1, 3, 11);
    idle(40);
    checkCounts("glitch_frame");

    $display("[TB] bad stop bit mid-payload");
    exp_err++;
    sendFrame(p_good, 8'h00, 4, -1, 5);
    idle(40);
    checkCounts("bad_stop");
    checkParams("bad_stop_hold", p_alt);
    exp_q.push_back(p_good);
    exp_load++;
    sendFrame(p_good, 8'h00, -1, -1, 11);
    idle(40);
    checkCounts("after_bad_stop");

    $display("[TB] timeout");
    exp_err++;
    sendFrame(p_alt, 8'h00, -1, -1, 4);
    idle(400);
    checkCounts("timeout");
    checkParams("timeout_hold", p_good);
    exp_q.push_back(p_good);
    exp_load++;
    sendFrame(p_good, 8'h00, -1, -1, 11);
    idle(40);
    checkCounts("after_timeout");

    $display("[TB] back-to-back frames");
    exp_q.push_back(p_alt);
    exp_q.push_back(p_last);
    exp_load += 2;
    sendFrame(p_alt, 8'h00, -1, -1, 11);
    sendFrame(p_last, 8'h00, -1, -1, 11);
    idle(40);
    checkCounts("b2b");
    checkParams("b2b_final", p_last);

    $display("[TB] reset mid-frame");
    sendFrame(p_alt, 8'h00, -1, -1, 5);
    reset = 1'b0;
    idle(5);
    reset = 1'b1;
    idle(1);
    checkParams("mid_reset", p_def);
    idle(400);
    checkCounts("mid_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
